// File: rtl/channel_pkg.sv
// channel_pkg: shared state type, LFSR constants and saturation helper for multipath_channel.
package channel_pkg;
  typedef enum logic [1:0] {IDLE, TAP, OUT} state_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form: bits 0,2,3,5 realise x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_MASK = 16'h002D;
  function automatic logic signed [31:0] sat_clip(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    return v > hi ? hi : (v < lo ? lo : v);
  endfunction
endpackage

// File: rtl/channel_lfsr.sv
// channel_lfsr: 16-bit Fibonacci LFSR noise source, advanced once per enabled cycle.
module channel_lfsr
  import channel_pkg::*;
#(
  parameter int NOISE_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      adv,
  output logic signed [NOISE_W-1:0] noise
);
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= LFSR_SEED;
    else if (adv) lfsr <= {^(lfsr & LFSR_MASK), lfsr[15:1]};
  end
  assign noise = lfsr[NOISE_W-1:0];
endmodule

// File: rtl/multipath_channel.sv
// multipath_channel: tapped circular delay line summing weighted echoes per accepted symbol.
// Define MULTIPATH_NOISE_EN to add LFSR noise before saturation.
module multipath_channel
  import channel_pkg::*;
#(
  parameter int SYM_W    = 2,
  parameter int OUT_W    = 14,
  parameter int DEPTH    = 16,
  parameter int NTAPS    = 2,
  parameter int GAIN_W   = 8,
  parameter int ATTEN_SH = 2,
  parameter int NOISE_W  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sym_valid,
  input  logic signed [SYM_W-1:0]        sym_in,
  output logic                           ready,
  input  logic [NTAPS*$clog2(DEPTH)-1:0] tap_delay,
  input  logic [NTAPS*GAIN_W-1:0]        tap_gain,
  output logic signed [OUT_W-1:0]        multi_out,
  output logic                           out_valid,
  output logic                           overrun,
  output logic                           sat
);
  localparam int PW = $clog2(DEPTH);
  localparam int KW = NTAPS > 1 ? $clog2(NTAPS) : 1;
  localparam int AW = SYM_W + GAIN_W + $clog2(NTAPS) + 1;
  state_t state, state_nxt;
  logic signed [SYM_W-1:0] dline [DEPTH];
  logic [PW-1:0] wr_ptr, base, rd_ptr;
  logic [KW-1:0] k;
  logic signed [AW-1:0] acc;
  logic signed [SYM_W+GAIN_W-1:0] prod;
  logic signed [31:0] noise, v, v_clip;
  logic accept, last;
  assign ready  = state == IDLE;
  assign accept = ready && sym_valid;
  assign last   = k == KW'(NTAPS - 1);
  // Modulo-DEPTH wrap falls out of the pointer width
  assign rd_ptr = base - tap_delay[k*PW +: PW];
  assign prod   = dline[rd_ptr] * $signed(tap_gain[k*GAIN_W +: GAIN_W]);
  assign v      = (32'(acc) >>> ATTEN_SH) + noise;
  assign v_clip = sat_clip(v, OUT_W);
`ifdef MULTIPATH_NOISE_EN
  logic signed [NOISE_W-1:0] lfsr_noise;
  channel_lfsr #(.NOISE_W(NOISE_W)) u_lfsr (
    .clk  (clk),
    .reset(reset),
    .adv  (state == OUT),
    .noise(lfsr_noise)
  );
  assign noise = 32'(lfsr_noise);
`else
  assign noise = '0;
`endif
  always_comb begin
    state_nxt = state == IDLE ? (sym_valid ? TAP : IDLE) :
                state == TAP  ? (last ? OUT : TAP) : IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      for (int i = 0; i < DEPTH; i++) dline[i] <= '0;
      wr_ptr    <= '0;
      base      <= '0;
      k         <= '0;
      acc       <= '0;
      multi_out <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      sat       <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      if (sym_valid && !ready) overrun <= 1'b1;
      if (accept) begin
        dline[wr_ptr] <= sym_in;
        base          <= wr_ptr;
        wr_ptr        <= wr_ptr + 1'b1;
        acc           <= '0;
        k             <= '0;
      end
      if (state == TAP) begin
        acc <= acc + AW'(prod);
        k   <= k + 1'b1;
      end
      if (state == OUT) begin
        multi_out <= v_clip[OUT_W-1:0];
        out_valid <= 1'b1;
        if (v_clip != v) sat <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_multipath_channel.sv
// tb_multipath_channel: directed checks of echo, wrap, saturation, overrun, abort and noise.
module tb_multipath_channel;
`ifdef MULTIPATH_NOISE_EN
  localparam bit NOISE_ON = 1'b1;
`else
  localparam bit NOISE_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;
  logic sv_a = 1'b0, sv_b = 1'b0;
  logic signed [1:0] s_a = '0, s_b = '0;
  logic [7:0] td_a = '0, td_b = '0;
  logic [15:0] tg_a = '0, tg_b = '0;
  logic rdy_a, rdy_b, ov_a, ov_b, or_a, or_b, sat_a, sat_b;
  logic signed [13:0] mo_a;
  logic signed [7:0] mo_b;
  int n_chk = 0, n_fail = 0;
  logic [15:0] m_lfsr [2];
  int sym_hist [20];

  multipath_channel dut_a (
    .clk(clk), .reset(reset_n), .sym_valid(sv_a), .sym_in(s_a), .ready(rdy_a),
    .tap_delay(td_a), .tap_gain(tg_a), .multi_out(mo_a), .out_valid(ov_a),
    .overrun(or_a), .sat(sat_a)
  );
  multipath_channel #(.OUT_W(8), .ATTEN_SH(0)) dut_b (
    .clk(clk), .reset(reset_n), .sym_valid(sv_b), .sym_in(s_b), .ready(rdy_b),
    .tap_delay(td_b), .tap_gain(tg_b), .multi_out(mo_b), .out_valid(ov_b),
    .overrun(or_b), .sat(sat_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clip(input int v, input int w);
    int hi = (1 << (w - 1)) - 1;
    return v > hi ? hi : (v < -hi - 1 ? -hi - 1 : v);
  endfunction

  task automatic nz(input int d, output int n);
    n = NOISE_ON ? int'($signed(m_lfsr[d][7:0])) : 0;
    m_lfsr[d] = {m_lfsr[d][0] ^ m_lfsr[d][2] ^ m_lfsr[d][3] ^ m_lfsr[d][5], m_lfsr[d][15:1]};
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset_n = 1'b0;
    m_lfsr[0] = 16'hACE1;
    m_lfsr[1] = 16'hACE1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send(input int d, input int s, output int val, output int lat);
    @(negedge clk);
    if (d == 0) begin sv_a = 1'b1; s_a = 2'(s); end
    else begin sv_b = 1'b1; s_b = 2'(s); end
    @(negedge clk);
    sv_a = 1'b0;
    sv_b = 1'b0;
    lat = 0;
    while (!(d == 0 ? ov_a : ov_b) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    val = d == 0 ? int'(mo_a) : int'(mo_b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v, lat, n, e, cnt, got;
    int e_sym [4] = '{1, 0, 0, 0};
    int e_exp [4] = '{16, 0, 0, 8};
    m_lfsr[0] = 16'hACE1;
    m_lfsr[1] = 16'hACE1;
    td_a = {4'd3, 4'd0};
    tg_a = {8'd32, 8'd64};
    td_b = '0;
    tg_b = {8'd127, 8'd127};
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out", int'(mo_a), 0);
    check("rst_valid", int'(ov_a), 0);
    check("rst_ready", int'(rdy_a), 1);
    check("rst_overrun", int'(or_a), 0);
    check("rst_sat", int'(sat_a), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(0, e_sym[i], v, lat);
      nz(0, n);
      check($sformatf("echo%0d", i), v, clip(e_exp[i] + n, 14));
      check($sformatf("echo_lat%0d", i), lat, 3);
    end
    check("echo_sat", int'(sat_a), 0);
    reset_dut();
    td_a = {4'd15, 4'd0};
    for (int i = 0; i < 20; i++) begin
      sym_hist[i] = i == 4 ? 1 : 0;
      send(0, sym_hist[i], v, lat);
      nz(0, n);
      e = (64 * sym_hist[i] + (i >= 15 ? 32 * sym_hist[i-15] : 0)) >>> 2;
      check($sformatf("wrap%0d", i), v, clip(e + n, 14));
    end
    send(1, -1, v, lat);
    nz(1, n);
    check("sat_val", v, clip(-254 + n, 8));
    check("sat_flag", int'(sat_b), 1);
    send(1, 0, v, lat);
    nz(1, n);
    check("sat_zero", v, clip(n, 8));
    check("sat_sticky", int'(sat_b), 1);
    reset_dut();
    td_a = {4'd3, 4'd0};
    @(negedge clk);
    sv_a = 1'b1;
    s_a = -2'sd1;
    @(negedge clk);
    s_a = 2'sd1;
    @(negedge clk);
    sv_a = 1'b0;
    cnt = 0;
    got = 0;
    repeat (8) begin
      if (ov_a) begin cnt++; got = int'(mo_a); end
      @(negedge clk);
    end
    nz(0, n);
    check("ovr_count", cnt, 1);
    check("ovr_val", got, clip(-16 + n, 14));
    check("ovr_flag", int'(or_a), 1);
    check("ovr_ready", int'(rdy_a), 1);
    @(negedge clk);
    sv_a = 1'b1;
    s_a = 2'sd1;
    @(negedge clk);
    sv_a = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(rdy_a), 0);
    reset_n = 1'b0;
    m_lfsr[0] = 16'hACE1;
    m_lfsr[1] = 16'hACE1;
    cnt = 0;
    repeat (3) begin @(negedge clk); cnt += int'(ov_a); end
    reset_n = 1'b1;
    repeat (5) begin @(negedge clk); cnt += int'(ov_a); end
    check("abort_valid", cnt, 0);
    check("abort_out", int'(mo_a), 0);
    check("abort_outb", int'(mo_b), 0);
    check("abort_overrun", int'(or_a), 0);
    check("abort_sat", int'(sat_b), 0);
    check("abort_ready", int'(rdy_a), 1);
    td_a = {4'd15, 4'd0};
    send(0, 0, v, lat);
    nz(0, n);
    check("abort_buf", v, clip(n, 14));
`ifdef MULTIPATH_NOISE_EN
    check("noise_first", v, -31);
`endif
    send(0, 0, v, lat);
    nz(0, n);
    check("probe2", v, clip(n, 14));
`ifdef MULTIPATH_NOISE_EN
    check("noise_adv", v, 112);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
